// File: rtl/spi_pkg.sv
// Shared types and widths for the 16-bit SPI responder.
// Imported by spi_sync_edge and spi_slv16.
package spi_pkg;

    localparam int SPI_WORD_W   = 16;
    localparam int SPI_BITCNT_W = 5;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } spi_slv_state_t;

    // Bit counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [SPI_BITCNT_W-1:0] bitcnt_sat_inc(
        input logic [SPI_BITCNT_W-1:0] v
    );
        return (&v) ? v : v + SPI_BITCNT_W'(1);
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Depth-parameterized synchronizer with registered rise/fall detect.
// q is delayed to stay cycle-aligned with rise and fall.
module spi_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;
    logic              rise_q;
    logic              fall_q;
    logic              last;

    assign last = sync_q[STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= last;
            rise_q <= last & ~prev_q;
            fall_q <= ~last & prev_q;
        end
    end

    assign q    = prev_q;
    assign rise = rise_q;
    assign fall = fall_q;

endmodule

// File: rtl/spi_slv16.sv
// 16-bit mode-0 SPI responder oversampled on clk.
// Define SPI_SLV_FRAME_CHK_EN to enable the frame_err bit-count check.
module spi_slv16
    import spi_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  SCLK,
    input  logic                  SS_n,
    input  logic                  MOSI,
    output logic                  MISO,
    input  logic [SPI_WORD_W-1:0] tx_data,
    output logic [SPI_WORD_W-1:0] cmd,
    output logic                  rdy,
    output logic                  busy,
    output logic                  frame_err
);

    localparam logic [SPI_BITCNT_W-1:0] FULL_CNT = SPI_BITCNT_W'(SPI_WORD_W);

    logic sclk_rise;
    logic sclk_fall;
    logic ss_rise;
    logic ss_fall;
    logic mosi_s;
    logic sclk_q_unused;
    logic ss_q_unused;
    logic mosi_rise_unused;
    logic mosi_fall_unused;

    spi_sync_edge #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b0)
    ) u_sync_sclk (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (SCLK),
        .q     (sclk_q_unused),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    spi_sync_edge #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b1)
    ) u_sync_ss (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (SS_n),
        .q     (ss_q_unused),
        .rise  (ss_rise),
        .fall  (ss_fall)
    );

    spi_sync_edge #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b0)
    ) u_sync_mosi (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (MOSI),
        .q     (mosi_s),
        .rise  (mosi_rise_unused),
        .fall  (mosi_fall_unused)
    );

    spi_slv_state_t          state_q, state_d;
    logic [SPI_WORD_W-1:0]   tx_q, tx_d;
    logic [SPI_WORD_W-1:0]   rx_q, rx_d;
    logic [SPI_BITCNT_W-1:0] cnt_q, cnt_d;
    logic [SPI_WORD_W-1:0]   cmd_q, cmd_d;
    logic                    rdy_q, rdy_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            tx_q    <= '0;
            rx_q    <= '0;
            cnt_q   <= '0;
            cmd_q   <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            cnt_q   <= cnt_d;
            cmd_q   <= cmd_d;
            rdy_q   <= rdy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        cnt_d   = cnt_q;
        cmd_d   = cmd_q;
        rdy_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ss_fall) begin
                    tx_d    = tx_data;
                    rx_d    = '0;
                    cnt_d   = '0;
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                if (ss_rise) begin
                    state_d = IDLE;
                    if (cnt_q == FULL_CNT) begin
                        cmd_d = rx_q;
                        rdy_d = 1'b1;
                    end
                end else begin
                    if (sclk_rise) begin
                        rx_d  = {rx_q[SPI_WORD_W-2:0], mosi_s};
                        cnt_d = bitcnt_sat_inc(cnt_q);
                    end
                    if (sclk_fall) begin
                        tx_d = {tx_q[SPI_WORD_W-2:0], 1'b0};
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Short/long frames are flagged only when the check is built in.
`ifdef SPI_SLV_FRAME_CHK_EN
    logic err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= (state_q == ACTIVE) && ss_rise && (cnt_q != FULL_CNT);
        end
    end

    assign frame_err = err_q;
`else
    assign frame_err = 1'b0;
`endif

    assign busy = (state_q == ACTIVE);
    assign MISO = (state_q == ACTIVE) & tx_q[SPI_WORD_W-1];
    assign cmd  = cmd_q;
    assign rdy  = rdy_q;

endmodule
